// File: rtl/wb_commit_arbiter.sv
// wb_commit_arbiter: round-robin writeback arbiter feeding a single registered commit slot
module wb_commit_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id,
  input  logic [NUM_UNITS*6-1:0]          unit_phys_addr,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_data,
  output logic [NUM_UNITS-1:0]            unit_ack,
  input  logic                            writeback_suppress,
  output logic                            commit_valid,
  output logic [ID_WIDTH-1:0]             commit_id,
  output logic [5:0]                      commit_phys_addr,
  output logic [DATA_WIDTH-1:0]           commit_data,
  input  logic                            commit_ready
);
  localparam int PW = $clog2(NUM_UNITS);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, win, idx;
  logic grant;
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_UNITS);
      win = unit_valid[idx] ? idx : win;
    end
  end
  assign grant = (state == EMPTY || commit_ready) && !writeback_suppress && !rst && |unit_valid;
  always_ff @(posedge clk) state <= rst ? EMPTY : state_nxt;
  always_comb state_nxt = grant ? FULL : (state == FULL && commit_ready) ? EMPTY : state;
  always_comb begin
    commit_valid = state == FULL && !rst;
    unit_ack = grant ? NUM_UNITS'(1) << win : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (grant) rr_ptr <= (win == PW'(NUM_UNITS - 1)) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (grant) begin
      commit_id <= unit_id[win*ID_WIDTH +: ID_WIDTH];
      commit_phys_addr <= unit_phys_addr[win*6 +: 6];
      commit_data <= unit_data[win*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule
